// File: rtl/acc_sign_test_pkg.sv
// rtl/acc_sign_test_pkg.sv - shared control-section order codes, states and jump decision
package acc_sign_test_pkg;

    typedef enum logic [1:0] {
        ORD_E = 2'd0,
        ORD_G = 2'd1,
        ORD_U = 2'd2
    } order_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        TAKEN = 2'd2
    } state_t;

    // sign = 1 means the accumulator is negative
    function automatic logic jump_taken(order_t order, logic sign);
        case (order)
            ORD_E:   return ~sign;
            ORD_G:   return sign;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/acc_sign_test_if.sv
// rtl/acc_sign_test_if.sv - sign-test handshake bundle between control unit and accumulator
interface acc_sign_test_if;
    logic s2;
    logic c25;
    logic c10;
    logic jump_uc;
    logic dv;
    logic odd_d35;
    logic acc_digit;
    logic ep_done;
    logic dv_d;
    logic acc_sign;
    logic test_err;

    modport master (
        output s2, c25, c10, jump_uc, dv, odd_d35, acc_digit, ep_done,
        input  dv_d, acc_sign, test_err
    );

    modport slave (
        input  s2, c25, c10, jump_uc, dv, odd_d35, acc_digit, ep_done,
        output dv_d, acc_sign, test_err
    );
endinterface

// File: rtl/acc_sign_test_sign_latch.sv
// rtl/acc_sign_test_sign_latch.sv - digit-time capture of the serial accumulator sign
module sign_latch (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d,
    output logic q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= 1'b0;
        else if (en)
            q <= d;
    end
endmodule

// File: rtl/acc_sign_test.sv
// rtl/acc_sign_test.sv - accumulator-side responder for the jump sign-test handshake
module acc_sign_test
    import acc_sign_test_pkg::*;
#(
    parameter int TIMEOUT_MC = 2
) (
    input logic           clk,
    input logic           rst,
    acc_sign_test_if.slave bus
);
    localparam int CW = ($clog2(TIMEOUT_MC + 1) < 1) ? 1 : $clog2(TIMEOUT_MC + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_MC);

    state_t        state, state_n;
    order_t        order, order_n;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic          dv_d_q, dv_d_n;
    logic          err_q, err_n;
    logic [2:0]    lines;
    logic          one_line, multi_line;

    sign_latch u_sign_latch (
        .clk (clk),
        .rst (rst),
        .en  (bus.odd_d35),
        .d   (bus.acc_digit),
        .q   (bus.acc_sign)
    );

    assign lines      = {bus.c25, bus.c10, bus.jump_uc};
    assign one_line   = $onehot(lines);
    assign multi_line = (|lines) & ~one_line;
    // saturating step so the counter can never wrap back into range
    assign cnt_inc    = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            order  <= ORD_E;
            cnt    <= '0;
            dv_d_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_n;
            order  <= order_n;
            cnt    <= cnt_n;
            dv_d_q <= dv_d_n;
            err_q  <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        order_n = order;
        cnt_n   = cnt;
        dv_d_n  = dv_d_q;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                dv_d_n = 1'b0;
                if (bus.dv)
                    err_n = 1'b1;
                if (bus.s2) begin
                    if (one_line) begin
                        order_n = bus.c25 ? ORD_E : (bus.c10 ? ORD_G : ORD_U);
                        cnt_n   = '0;
                        state_n = ARMED;
                    end else if (multi_line) begin
                        err_n = 1'b1;
                    end
                end
            end
            ARMED: begin
                if (bus.dv) begin
                    if (bus.odd_d35 && jump_taken(order, bus.acc_digit)) begin
                        dv_d_n  = 1'b1;
                        state_n = TAKEN;
                    end else begin
                        err_n   = ~bus.odd_d35;
                        state_n = IDLE;
                    end
                end else if (bus.odd_d35) begin
                    cnt_n = cnt_inc;
                    if (cnt_inc >= CNT_MAX) begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            TAKEN: begin
                dv_d_n = 1'b1;
                if (bus.ep_done) begin
                    dv_d_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            default: begin
                dv_d_n  = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    assign bus.dv_d     = dv_d_q;
    assign bus.test_err = err_q;

endmodule

// File: tb/tb_acc_sign_test.sv
// tb/tb_acc_sign_test.sv - directed self-checking bench for acc_sign_test
module tb_acc_sign_test;
    import acc_sign_test_pkg::*;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    acc_sign_test_if bif ();

    acc_sign_test #(.TIMEOUT_MC(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bif.s2 = 0; bif.c25 = 0; bif.c10 = 0; bif.jump_uc = 0;
        bif.dv = 0; bif.odd_d35 = 0; bif.acc_digit = 0; bif.ep_done = 0;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_test(input string tag, input logic e, input logic g, input logic u,
                            input logic sign, input logic exp_taken);
        bif.s2 = 1; bif.c25 = e; bif.c10 = g; bif.jump_uc = u;
        tick();
        clr();
        chk({tag, " armed"}, dut.state, ARMED);
        tick();
        tick();
        bif.dv = 1; bif.odd_d35 = 1; bif.acc_digit = sign;
        tick();
        clr();
        chk({tag, " dv_d"}, bif.dv_d, exp_taken);
        chk({tag, " acc_sign"}, bif.acc_sign, sign);
        chk({tag, " no_err"}, bif.test_err, 0);
        if (exp_taken) begin
            tick();
            chk({tag, " dv_d held"}, bif.dv_d, 1);
            bif.ep_done = 1;
            tick();
            clr();
            chk({tag, " dv_d released"}, bif.dv_d, 0);
        end
        chk({tag, " idle"}, dut.state, IDLE);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        clr();
        rst = 1;
        tick();
        tick();
        chk("reset dv_d", bif.dv_d, 0);
        chk("reset acc_sign", bif.acc_sign, 0);
        chk("reset test_err", bif.test_err, 0);
        chk("reset state", dut.state, IDLE);
        rst = 0;
        tick();

        run_test("E pos", 1, 0, 0, 0, 1);
        run_test("E neg", 1, 0, 0, 1, 0);
        run_test("G neg", 0, 1, 0, 1, 1);
        run_test("G pos", 0, 1, 0, 0, 0);
        run_test("U pos", 0, 0, 1, 0, 1);
        run_test("U neg", 0, 0, 1, 1, 1);

        // two order lines with s2
        bif.s2 = 1; bif.c25 = 1; bif.c10 = 1;
        tick();
        clr();
        chk("multi err", bif.test_err, 1);
        chk("multi idle", dut.state, IDLE);
        chk("multi dv_d", bif.dv_d, 0);
        tick();
        chk("multi err one cycle", bif.test_err, 0);

        // dv while idle
        bif.dv = 1;
        tick();
        clr();
        chk("idle dv err", bif.test_err, 1);
        chk("idle dv state", dut.state, IDLE);
        tick();
        chk("idle dv err one cycle", bif.test_err, 0);

        // dv without odd_d35 while armed
        bif.s2 = 1; bif.c25 = 1;
        tick();
        clr();
        bif.dv = 1;
        tick();
        clr();
        chk("armed dv err", bif.test_err, 1);
        chk("armed dv idle", dut.state, IDLE);
        chk("armed dv dv_d", bif.dv_d, 0);
        tick();
        chk("armed dv err one cycle", bif.test_err, 0);

        // timeout after two strobes
        bif.s2 = 1; bif.c25 = 1;
        tick();
        clr();
        bif.odd_d35 = 1;
        tick();
        chk("timeout strobe1 err", bif.test_err, 0);
        chk("timeout strobe1 armed", dut.state, ARMED);
        tick();
        clr();
        chk("timeout strobe2 err", bif.test_err, 1);
        chk("timeout idle", dut.state, IDLE);
        tick();
        chk("timeout err one cycle", bif.test_err, 0);
        bif.dv = 1;
        tick();
        clr();
        chk("late dv err", bif.test_err, 1);

        // asynchronous reset while TAKEN
        bif.s2 = 1; bif.jump_uc = 1;
        tick();
        clr();
        bif.dv = 1; bif.odd_d35 = 1; bif.acc_digit = 1;
        tick();
        clr();
        chk("pre-reset dv_d", bif.dv_d, 1);
        chk("pre-reset acc_sign", bif.acc_sign, 1);
        #2;
        rst = 1;
        #1;
        chk("async reset dv_d", bif.dv_d, 0);
        chk("async reset acc_sign", bif.acc_sign, 0);
        chk("async reset state", dut.state, IDLE);
        #3;
        rst = 0;
        tick();
        run_test("E after reset", 1, 0, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/acc_sign_test.md
# acc_sign_test

Accumulator-side responder for the control section's jump sign-test handshake. It arms on the stimulating pulse for an E, G or unconditional jump order and samples the accumulator sign digit when the control unit's `dv` pulse arrives. It returns `dv_d` when the jump is to be taken and holds it until the transfer end pulse completes. It sits in the arithmetic section, alongside the serial accumulator, and pairs with the control unit that issues `dv` and consumes `dv_d`.

## Interface
- `TIMEOUT_MC`, default 2: number of `odd_d35` digit times an armed test waits for `dv` before it aborts.
- `clk` input 1: system clock; one clock per digit time.
- `rst` input 1: reset, asynchronous, active-high.
- `s2` input 1: stimulating pulse from the MCU.
- `c25` input 1: E order decoded; jump if accumulator is at least 0.
- `c10` input 1: G order decoded; jump if accumulator is below 0.
- `jump_uc` input 1: unconditional jump.
- `dv` input 1: sign-test pulse from the control unit.
- `odd_d35` input 1: digit-time strobe for the sign digit of the odd minor cycle.
- `acc_digit` input 1: serial accumulator output, LSB first; it carries the sign at `odd_d35`.
- `ep_done` input 1: end-pulse completion; releases the response.
- `dv_d` output 1: jump-taken response, registered level.
- `acc_sign` output 1: last captured accumulator sign; 1 means negative.
- `test_err` output 1: one-cycle protocol error pulse.

## Operation
- Order codes are `ORD_E`, `ORD_G` and `ORD_U`. Exactly one of `c25`, `c10` and `jump_uc` must be high with `s2`.
- `acc_sign` is loaded from `acc_digit` on every clock edge where `odd_d35`=1, regardless of state.
- The FSM has three states: `IDLE`, `ARMED` and `TAKEN`.
- `IDLE`, on `s2` with exactly one order line high:
  - latch the order code;
  - clear the timeout counter;
  - go to `ARMED`.
- `IDLE`, on `s2` with two or more order lines high: pulse `test_err` and stay in `IDLE`.
- `IDLE`, on `dv`: pulse `test_err`; the pulse is otherwise ignored.
- `ARMED`, on `dv` with `odd_d35`: evaluate the condition using the live `acc_digit` as the sign.
  - `ORD_E` is taken when the sign is 0.
  - `ORD_G` is taken when the sign is 1.
  - `ORD_U` is always taken.
  - If taken, go to `TAKEN` and set `dv_d`. If not taken, go to `IDLE`; `dv_d` stays 0.
- `ARMED`, on `dv` without `odd_d35`: pulse `test_err` and go to `IDLE`.
- `ARMED`, on `odd_d35` without `dv`: increment the counter. When the counter reaches `TIMEOUT_MC`, pulse `test_err` and go to `IDLE`.
- `ARMED`: `ep_done` and `s2` are ignored.
- `TAKEN`: `dv_d` is held at 1. On `ep_done`, clear `dv_d` and go to `IDLE`. `s2` and `dv` are ignored.

## Timing
- Reset values: state `IDLE`, `dv_d`=0, `acc_sign`=0, `test_err`=0, counter 0, order code `ORD_E`.
- Reset mid-operation clears everything immediately; any held `dv_d` drops without waiting for a clock.
- `dv_d` rises on the clock edge that samples `dv`. It is visible in the cycle after `dv`, before the control unit's test flip-flop clears.
- `dv_d` falls on the edge that samples `ep_done`.
- Minimum `s2`-to-`dv` spacing is 1 clock. A `dv` in the same cycle as an arming `s2` counts as `dv` while in `IDLE`, which is an error.
- Simultaneous `dv` and `odd_d35` in `ARMED`:
  - the sign decision uses `acc_digit` from that same cycle;
  - `acc_sign` updates on the same edge to the same value;
  - the timeout counter does not increment.
- `test_err` is high for exactly one clock per error event.
- The counter is wide enough for `TIMEOUT_MC`; it saturates and never wraps.

## Structure
- Order codes `ORD_E`, `ORD_G`, `ORD_U` and the state encodings go in the shared control-section definitions include, so they are shared with the control units.
- The design is a single module with one sub-module, `sign_latch`: the digit-time sign capture register feeding `acc_sign`. The arithmetic section's other units reuse it.

## Test plan
- **E, positive:** `s2`+`c25`; 3 clocks later `dv`+`odd_d35` with `acc_digit`=0. Required: `dv_d`=1 the next cycle, held until `ep_done`, then 0; `acc_sign`=0.
- **E, negative:** same stimulus with `acc_digit`=1. Required: `dv_d` never rises, FSM returns to `IDLE`, `acc_sign`=1.
- **G and unconditional:** `s2`+`c10` with sign 1 gives `dv_d`=1; with sign 0 gives `dv_d`=0. `s2`+`jump_uc` gives `dv_d`=1 for either sign.
- **Protocol errors:** each of the following gives a one-cycle `test_err` and leaves `IDLE` with `dv_d`=0:
  - `s2` with `c25`+`c10`;
  - `dv` in `IDLE`;
  - `dv` without `odd_d35` while `ARMED`.
- **Timeout:** arm with `ORD_E`, then give 2 `odd_d35` strobes and no `dv`. Required: `test_err` on the second strobe, FSM in `IDLE`; a later `dv` gives `test_err` again.
- **Reset in `TAKEN`:** assert `rst` mid-cycle while `dv_d`=1. Required: `dv_d`=0 immediately; after release, a fresh E test behaves normally.
